// File: rtl/cpu_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// cpu_mem_arbiter_if
// Pipelined Wishbone bus between the CPU memory arbiter (master) and the
// memory/peripheral fabric (slave).
//
// Signals (named from the master's point of view):
//   o_wb_cyc    master -> slave   bus cycle in progress
//   o_wb_stb    master -> slave   request strobe, held while stalled
//   o_we        master -> slave   1 = write
//   o_addr      master -> slave   word-aligned byte address
//   o_data      master -> slave   write data, replicated across lanes
//   o_wb_sel    master -> slave   byte-lane select
//   i_data      slave  -> master  read data
//   i_wb_ack    slave  -> master  access acknowledged
//   i_wb_stall  slave  -> master  request not accepted this cycle
//   i_wb_err    slave  -> master  access failed
// ---------------------------------------------------------------------------
interface cpu_mem_arbiter_if #(
    parameter int ADDR_W = 32
) ();
    logic              o_wb_cyc;
    logic              o_wb_stb;
    logic              o_we;
    logic [ADDR_W-1:0] o_addr;
    logic [31:0]       o_data;
    logic [3:0]        o_wb_sel;
    logic [31:0]       i_data;
    logic              i_wb_ack;
    logic              i_wb_stall;
    logic              i_wb_err;

    modport master (
        output o_wb_cyc, o_wb_stb, o_we, o_addr, o_data, o_wb_sel,
        input  i_data, i_wb_ack, i_wb_stall, i_wb_err
    );

    modport slave (
        input  o_wb_cyc, o_wb_stb, o_we, o_addr, o_data, o_wb_sel,
        output i_data, i_wb_ack, i_wb_stall, i_wb_err
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_mem_arbiter
// Shared pipelined-Wishbone master for the CPU. N_CH requesters (ch0 = fetch,
// ch1 = load/store, higher channels for DMA/debug) are granted round-robin,
// one access in flight. Handles byte/half/word lane selection, read
// sign/zero extension, misalignment, bus error and ack timeout.
//
// Ports:
//   clk, reset            clock (posedge), asynchronous active-high reset
//   i_req[N_CH]           per-channel request level, held until done/err
//   i_we[N_CH]            per-channel write enable
//   i_size[2*N_CH]        per-channel size: 0 byte, 1 half, 2 word, 3 invalid
//   i_signed[N_CH]        per-channel sign-extend read data
//   i_addr[ADDR_W*N_CH]   per-channel byte address
//   i_wdata[32*N_CH]      per-channel right-justified write data
//   o_done[N_CH]          one-cycle pulse, access completed
//   o_err[N_CH]           one-cycle pulse, access failed
//   o_rdata[32]           extended read data of the last completed read
//   wb                    Wishbone master modport
// ---------------------------------------------------------------------------
module cpu_mem_arbiter #(
    parameter int N_CH      = 2,
    parameter int ADDR_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH-1:0]        i_req,
    input  logic [N_CH-1:0]        i_we,
    input  logic [2*N_CH-1:0]      i_size,
    input  logic [N_CH-1:0]        i_signed,
    input  logic [ADDR_W*N_CH-1:0] i_addr,
    input  logic [32*N_CH-1:0]     i_wdata,
    output logic [N_CH-1:0]        o_done,
    output logic [N_CH-1:0]        o_err,
    output logic [31:0]            o_rdata,
    cpu_mem_arbiter_if.master      wb
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [TIMEOUT_W-1:0] TLAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_FAIL} state_t;

    state_t                r_state;
    logic [CH_W-1:0]       r_ptr;
    logic [CH_W-1:0]       r_grant;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [1:0]            r_lane;
    logic [TIMEOUT_W-1:0]  r_timer;
    logic                  r_misPend;
    logic [N_CH-1:0]       r_done;
    logic [N_CH-1:0]       r_err;
    logic [31:0]           r_rdata;

    logic [CH_W-1:0]       w_grant;
    logic                  w_anyReq;
    int                    w_idx;
    logic                  w_we;
    logic [1:0]            w_size;
    logic                  w_signed;
    logic [ADDR_W-1:0]     w_addr;
    logic [31:0]           w_wdata;
    logic                  w_misalign;
    logic [3:0]            w_sel;
    logic [31:0]           w_data;
    logic [N_CH-1:0]       w_grantOh;
    logic [CH_W-1:0]       w_nextPtr;
    logic [31:0]           w_shifted;
    logic [31:0]           w_rdExt;

    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_rdata = r_rdata;

    // Round-robin pick: walk offsets from the highest down so the last
    // match written is the requester closest at or after the pointer.
    always_comb begin
        w_grant  = r_ptr;
        w_anyReq = 1'b0;
        w_idx    = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N_CH) begin
                w_idx = w_idx - N_CH;
            end
            if (i_req[CH_W'(w_idx)]) begin
                w_grant  = CH_W'(w_idx);
                w_anyReq = 1'b1;
            end
        end
    end

    // Steer the candidate channel's request fields, and decode the current
    // grant into a one-hot mask for the done/err pulses.
    always_comb begin
        w_we      = 1'b0;
        w_size    = 2'd0;
        w_signed  = 1'b0;
        w_addr    = '0;
        w_wdata   = 32'd0;
        w_grantOh = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_grant == CH_W'(k)) begin
                w_we     = i_we[k];
                w_size   = i_size[2*k +: 2];
                w_signed = i_signed[k];
                w_addr   = i_addr[ADDR_W*k +: ADDR_W];
                w_wdata  = i_wdata[32*k +: 32];
            end
            w_grantOh[k] = (r_grant == CH_W'(k));
        end
    end

    // Byte-lane select and lane replication for the candidate request; size 3
    // is folded into the misalignment check so it never reaches the bus.
    always_comb begin
        w_sel  = 4'hF;
        w_data = w_wdata;
        case (w_size)
            2'd0: begin
                w_sel  = 4'b0001 << w_addr[1:0];
                w_data = {4{w_wdata[7:0]}};
            end
            2'd1: begin
                w_sel  = 4'b0011 << w_addr[1:0];
                w_data = {2{w_wdata[15:0]}};
            end
            default: begin
            end
        endcase
        w_misalign = (w_size == 2'd3) ||
                     (w_size == 2'd1 && w_addr[0]) ||
                     (w_size == 2'd2 && w_addr[1:0] != 2'b00);
        w_nextPtr  = (r_grant == CH_W'(N_CH - 1)) ? '0 : r_grant + 1'b1;
    end

    // Read lane: shift the addressed lane down to bit 0, then extend
    // according to the latched size and signedness.
    always_comb begin
        w_shifted = wb.i_data >> {r_lane, 3'b000};
        case (r_size)
            2'd0:    w_rdExt = r_signed ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                        : {24'd0, w_shifted[7:0]};
            2'd1:    w_rdExt = r_signed ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                        : {16'd0, w_shifted[15:0]};
            default: w_rdExt = w_shifted;
        endcase
    end

    // Access sequencer. All bus controls and pulses are registered. A
    // misaligned request spends one silent cycle in FAIL (r_misPend) before
    // pulsing o_err, so the requester sees the error two cycles after asking,
    // then FAIL returns to IDLE after the pulse just like the bus-error path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_size      <= 2'd0;
            r_signed    <= 1'b0;
            r_lane      <= 2'd0;
            r_timer     <= '0;
            r_misPend   <= 1'b0;
            r_done      <= '0;
            r_err       <= '0;
            r_rdata     <= 32'd0;
            wb.o_wb_cyc <= 1'b0;
            wb.o_wb_stb <= 1'b0;
            wb.o_we     <= 1'b0;
            wb.o_addr   <= '0;
            wb.o_data   <= 32'd0;
            wb.o_wb_sel <= 4'd0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_anyReq) begin
                        r_grant  <= w_grant;
                        r_size   <= w_size;
                        r_signed <= w_signed;
                        r_lane   <= w_addr[1:0];
                        if (w_misalign) begin
                            r_misPend <= 1'b1;
                            r_state   <= S_FAIL;
                        end else begin
                            wb.o_wb_cyc <= 1'b1;
                            wb.o_wb_stb <= 1'b1;
                            wb.o_we     <= w_we;
                            wb.o_addr   <= {w_addr[ADDR_W-1:2], 2'b00};
                            wb.o_data   <= w_data;
                            wb.o_wb_sel <= w_sel;
                            r_state     <= S_REQ;
                        end
                    end
                end
                S_REQ, S_WAIT: begin
                    if (r_state == S_REQ && wb.i_wb_stall) begin
                        r_state <= S_REQ;
                    end else if (wb.i_wb_err) begin
                        wb.o_wb_cyc <= 1'b0;
                        wb.o_wb_stb <= 1'b0;
                        r_err       <= w_grantOh;
                        r_state     <= S_FAIL;
                    end else if (wb.i_wb_ack) begin
                        wb.o_wb_cyc <= 1'b0;
                        wb.o_wb_stb <= 1'b0;
                        r_done      <= w_grantOh;
                        if (!wb.o_we) begin
                            r_rdata <= w_rdExt;
                        end
                        r_state <= S_DONE;
                    end else if (r_state == S_REQ) begin
                        wb.o_wb_stb <= 1'b0;
                        r_timer     <= '0;
                        r_state     <= S_WAIT;
                    end else if (r_timer == TLAST) begin
                        wb.o_wb_cyc <= 1'b0;
                        r_err       <= w_grantOh;
                        r_state     <= S_FAIL;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DONE: begin
                    r_ptr   <= w_nextPtr;
                    r_state <= S_IDLE;
                end
                S_FAIL: begin
                    if (r_misPend) begin
                        r_misPend <= 1'b0;
                        r_err     <= w_grantOh;
                    end else begin
                        r_ptr   <= w_nextPtr;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
